// File: rtl/fetch_pkg.sv
// Shared defaults for the instruction-fetch front end.
// Also holds the instruction value presented while the buffer is empty or in reset.
package fetch_pkg;

    localparam int unsigned DEF_ADDR_W   = 12;
    localparam int unsigned DEF_DATA_W   = 32;
    localparam int unsigned DEF_RESET_PC = 0;
    localparam int unsigned DEF_BUF_DEPTH = 2;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

endpackage : fetch_pkg

// File: rtl/fetch_buffer.sv
// Small FIFO holding {pc, instruction} entries between imem and decode.
// A synchronous flush discards every entry and takes priority over push/pop.
module fetch_buffer #(
    parameter int WIDTH = 44,
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [CNT_W-1:0] count_o,
    output logic             head_valid_o,
    output logic [WIDTH-1:0] head_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the top gates the head while the buffer is empty.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign count_o      = count_q;
    assign head_valid_o = (count_q != '0);
    assign head_o       = mem_q[rd_ptr_q];

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_i && !pop_i && !flush_i && (count_q == CNT_W'(DEPTH))));
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(pop_i && !flush_i && (count_q == '0)));

endmodule : fetch_buffer

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues imem reads under a credit
// rule so the buffer never overflows, and redirects/flushes on taken branches.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          ADDR_W    = DEF_ADDR_W,
    parameter int          DATA_W    = DEF_DATA_W,
    parameter int unsigned RESET_PC  = DEF_RESET_PC,
    parameter int          BUF_DEPTH = DEF_BUF_DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] address_imem,
    input  logic [DATA_W-1:0] q_imem,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc
);

    localparam int CNT_W   = $clog2(BUF_DEPTH + 1);
    localparam int ENTRY_W = DATA_W + ADDR_W;

    logic [ADDR_W-1:0]  pc_fetch_q, pc_fetch_d;
    logic [ADDR_W-1:0]  pc_inflight_q, pc_inflight_d;
    logic               inflight_q, inflight_d;
    logic [CNT_W-1:0]   buf_count;
    logic               buf_valid;
    logic [ENTRY_W-1:0] buf_head;
    logic               pop;
    logic               issue;
    logic [CNT_W:0]     occupancy;

    assign pop = buf_valid & instr_ready;

    // Entries already buffered plus the read in flight, minus the one leaving now.
    assign occupancy = {1'b0, buf_count} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop);
    assign issue     = ~redirect_valid & (occupancy < (CNT_W + 1)'(BUF_DEPTH));

    always_comb begin
        pc_fetch_d    = pc_fetch_q;
        pc_inflight_d = pc_inflight_q;
        inflight_d    = 1'b0;
        if (redirect_valid) begin
            pc_fetch_d = redirect_pc;
        end else if (issue) begin
            pc_fetch_d    = pc_fetch_q + ADDR_W'(1);
            pc_inflight_d = pc_fetch_q;
            inflight_d    = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_fetch_q    <= ADDR_W'(RESET_PC);
            pc_inflight_q <= '0;
            inflight_q    <= 1'b0;
        end else begin
            pc_fetch_q    <= pc_fetch_d;
            pc_inflight_q <= pc_inflight_d;
            inflight_q    <= inflight_d;
        end
    end

    // The flush also drops the response arriving in the redirect cycle.
    fetch_buffer #(
        .WIDTH (ENTRY_W),
        .DEPTH (BUF_DEPTH)
    ) u_buffer (
        .clk_i       (clock),
        .rst_ni      (reset),
        .push_i      (inflight_q),
        .push_data_i ({pc_inflight_q, q_imem}),
        .pop_i       (pop),
        .flush_i     (redirect_valid),
        .count_o     (buf_count),
        .head_valid_o(buf_valid),
        .head_o      (buf_head)
    );

    assign address_imem = pc_fetch_q;
    assign instr_valid  = buf_valid;
    assign instr        = buf_valid ? buf_head[DATA_W-1:0] : DATA_W'(INSTR_NOP);
    assign instr_pc     = buf_valid ? buf_head[ENTRY_W-1:DATA_W] : '0;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a one-cycle-latency imem model whose
// word n holds 32'hA000_0000 + n.
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] address_imem;
    logic [31:0] q_imem = '0;
    logic        redirect_valid = 1'b0;
    logic [11:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [11:0] instr_pc;

    int checks   = 0;
    int failures = 0;

    fetch_unit dut (
        .clock         (clock),
        .reset         (reset),
        .address_imem  (address_imem),
        .q_imem        (q_imem),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc)
    );

    always #5 clock = ~clock;

    always @(posedge clock) q_imem <= 32'hA000_0000 + {20'h0, address_imem};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #2;
    endtask

    task automatic chk_instr(input string tag, input logic [11:0] pc);
        chk({tag, "_vld"}, 64'(instr_valid), 64'd1);
        chk({tag, "_pc"}, 64'(instr_pc), 64'(pc));
        chk({tag, "_ins"}, 64'(instr), 64'(32'hA000_0000 + {20'h0, pc}));
    endtask

    // Leaves the bench in cycle 0: first cycle after reset release.
    task automatic do_reset();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        repeat (2) @(posedge clock);
        #2;
        chk("rst_addr", 64'(address_imem), 64'd0);
        chk("rst_vld", 64'(instr_valid), 64'd0);
        chk("rst_ins", 64'(instr), 64'd0);
        chk("rst_pc", 64'(instr_pc), 64'd0);
        reset = 1'b1;
    endtask

    initial begin
        // Streaming from reset with the consumer always ready.
        instr_ready = 1'b1;
        do_reset();
        chk("s1_c0_addr", 64'(address_imem), 64'd0);
        chk("s1_c0_vld", 64'(instr_valid), 64'd0);
        next_cycle();
        chk("s1_c1_addr", 64'(address_imem), 64'd1);
        chk("s1_c1_vld", 64'(instr_valid), 64'd0);
        for (int c = 2; c <= 9; c++) begin
            next_cycle();
            chk_instr($sformatf("s1_c%0d", c), 12'(c - 2));
        end

        // Redirect in cycle 10 (head is pc 8, popped in the same cycle).
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 12'h100;
        #1;
        chk_instr("s3_c10", 12'd8);
        next_cycle();
        redirect_valid = 1'b0;
        chk("s3_c11_addr", 64'(address_imem), 64'h100);
        chk("s3_c11_vld", 64'(instr_valid), 64'd0);
        next_cycle();
        chk("s3_c12_vld", 64'(instr_valid), 64'd0);
        next_cycle();
        chk_instr("s3_c13", 12'h100);
        next_cycle();
        chk_instr("s3_c14", 12'h101);

        // Redirect to the top of the address space and wrap.
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 12'hFFF;
        next_cycle();
        redirect_valid = 1'b0;
        next_cycle();
        chk("s4_vld", 64'(instr_valid), 64'd0);
        next_cycle();
        chk_instr("s4_a", 12'hFFF);
        next_cycle();
        chk_instr("s4_b", 12'h000);
        next_cycle();
        chk_instr("s4_c", 12'h001);

        // Back-to-back redirects: the second target wins.
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 12'h300;
        next_cycle();
        redirect_pc    = 12'h400;
        chk("s7_k1_vld", 64'(instr_valid), 64'd0);
        next_cycle();
        redirect_valid = 1'b0;
        chk("s7_k2_addr", 64'(address_imem), 64'h400);
        chk("s7_k2_vld", 64'(instr_valid), 64'd0);
        next_cycle();
        chk("s7_k3_vld", 64'(instr_valid), 64'd0);
        next_cycle();
        chk_instr("s7_k4", 12'h400);
        next_cycle();
        chk_instr("s7_k5", 12'h401);

        // Backpressure: consumer stalled in cycles 0..6, ready from cycle 7.
        instr_ready = 1'b0;
        do_reset();
        next_cycle();
        for (int c = 2; c <= 6; c++) begin
            next_cycle();
            chk_instr($sformatf("s2_c%0d", c), 12'd0);
            chk($sformatf("s2_c%0d_addr", c), 64'(address_imem), 64'd2);
        end
        next_cycle();
        instr_ready = 1'b1;
        for (int c = 7; c <= 10; c++) begin
            chk_instr($sformatf("s2_c%0d", c), 12'(c - 7));
            next_cycle();
        end

        // Redirect while popping from a full buffer.
        instr_ready = 1'b0;
        do_reset();
        repeat (5) next_cycle();
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 12'h200;
        #1;
        chk_instr("s5_c5", 12'd0);
        next_cycle();
        redirect_valid = 1'b0;
        chk("s5_c6_vld", 64'(instr_valid), 64'd0);
        chk("s5_c6_addr", 64'(address_imem), 64'h200);
        next_cycle();
        chk("s5_c7_vld", 64'(instr_valid), 64'd0);
        next_cycle();
        chk_instr("s5_c8", 12'h200);
        next_cycle();
        chk_instr("s5_c9", 12'h201);

        // Asynchronous reset mid-stream with a full buffer.
        instr_ready = 1'b0;
        do_reset();
        repeat (4) next_cycle();
        chk_instr("s6_pre", 12'd0);
        reset = 1'b0;
        #1;
        chk("s6_rst_vld", 64'(instr_valid), 64'd0);
        chk("s6_rst_addr", 64'(address_imem), 64'd0);
        chk("s6_rst_ins", 64'(instr), 64'd0);
        instr_ready = 1'b1;
        do_reset();
        chk("s6_c0_vld", 64'(instr_valid), 64'd0);
        next_cycle();
        chk("s6_c1_vld", 64'(instr_valid), 64'd0);
        for (int c = 2; c <= 4; c++) begin
            next_cycle();
            chk_instr($sformatf("s6_c%0d", c), 12'(c - 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fetch_unit

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch front end sitting between the imem syncram and the processor's decode logic. Owns the PC and drives address_imem. Captures q_imem into a small instruction buffer tagged with its PC, and hands instructions to the processor over a valid/ready handshake. Supports branch/jump redirect with flush of in-flight and buffered instructions.

Parameters:
ADDR_W, 12, imem word-address width (matches address_imem)
DATA_W, 32, instruction width (matches q_imem)
RESET_PC, 0, PC loaded on reset
BUF_DEPTH, 2, instruction buffer entries (minimum 2 for 1 instr/cycle)

Ports:
clock  in  1  single clock, rising-edge
reset  in  1  asynchronous, active-low reset (0 = in reset)
address_imem  out  ADDR_W  imem read address
q_imem  in  DATA_W  imem data; valid the cycle after address_imem is sampled
redirect_valid  in  1  branch/jump taken; flush and refetch
redirect_pc  in  ADDR_W  target PC when redirect_valid=1
instr_valid  out  1  instr/instr_pc hold a valid instruction
instr_ready  in  1  consumer accepts instr this cycle
instr  out  DATA_W  instruction at buffer head
instr_pc  out  ADDR_W  PC of instr

Behaviour:
- Reset (reset=0, async): pc_fetch=RESET_PC, inflight=0, buffer empty, count=0; outputs address_imem=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
- address_imem = pc_fetch (registered, no combinational path from inputs).
- pop = instr_valid & instr_ready.
- issue = ~redirect_valid & (count + inflight - pop < BUF_DEPTH). On issue: pc_fetch <= pc_fetch+1 (mod 2^ADDR_W, 4095 wraps to 0), inflight <= 1. Otherwise inflight <= 0 and pc_fetch holds.
- Response: when inflight=1 in a cycle, q_imem is pushed into the buffer at that cycle's end with tag pc_fetch-1 (the issued PC, carried in a registered pc_inflight). When inflight=0, q_imem is ignored.
- Buffer: FIFO, push and pop in the same cycle are both legal. The head drives instr/instr_pc. instr_valid = (count != 0). Credit rule guarantees no overflow, so push into a full buffer cannot occur. Pop when empty is impossible (instr_valid=0). instr holds its value while instr_valid=1 and instr_ready=0.
- Latency: the first cycle after reset release issues RESET_PC. q_imem is valid cycle 1. instr_valid=1 with instr_pc=RESET_PC in cycle 2. Steady-state throughput is 1 instr/cycle with instr_ready held 1.
- Redirect (redirect_valid=1 in cycle k): at the edge, buffer flushed (count=0), inflight<=0 so the cycle k+1 response is dropped, pc_fetch<=redirect_pc. No issue in cycle k. A pop in cycle k is still a completed handshake; the consumer owns that instruction. Cycle k+1 issues redirect_pc. instr_valid=0 in k+1 and k+2. The target appears in k+3.
- Back-to-back redirects: the last one wins; each restarts the k+3 latency.
- Reset mid-operation: immediate return to reset state regardless of inflight/buffer contents. Nothing from before reset may surface afterwards.

Decomposition:
- Shared package fetch_pkg: ADDR_W, DATA_W, RESET_PC defaults. Constant INSTR_NOP = 32'h0000_0000, used as the reset value of instr.
- One sub-module: fetch_buffer. Parameterised FIFO (width DATA_W+ADDR_W, depth BUF_DEPTH) with push, pop, synchronous flush, count, head outputs, and async active-low reset. fetch_unit holds the PC/inflight/credit logic.

Test Plan:
- Reset then instr_ready=1, imem[n]=32'hA000_0000+n -> instr_valid rises cycle 2. instr_pc=0,1,2,… one per cycle. instr=32'hA000_0000,…A000_0001,…
- instr_ready=0 for cycles 2–6 -> instr stays A000_0000/pc 0. count saturates at 2. address_imem stops advancing at 2. After instr_ready=1, pcs 0,1,2,3 arrive with no gap or duplicate.
- Redirect_valid=1, redirect_pc=12'h100 in cycle 10 -> address_imem=12'h100 in cycle 11. instr_valid=0 in cycles 11–12. instr_pc=12'h100 in cycle 13. No stale pc (9/10/11) appears.
- Redirect with redirect_pc=12'hFFF -> instr_pc sequence 12'hFFF, 12'h000, 12'h001 (wrap).
- Redirect in the same cycle as pop with a full buffer -> popped instr is accepted once. The buffer is empty next cycle. No overflow or assertion fires.
- Assert reset=0 while count=2 and inflight=1 -> instr_valid=0 and address_imem=RESET_PC immediately. After release, the sequence restarts at RESET_PC.
